// File: rtl/priv_1_12_csr_arb.sv
// rtl/priv_1_12_csr_arb.sv - two-requester CSR port arbiter (pipeline/debug) with issue/response FSM
// Optional PRIV_CSR_ARB_RR_EN: round-robin arbitration instead of pipeline priority with starvation counter.
module priv_1_12_csr_arb
`ifndef PRIV_CSR_ARB_RR_EN
#(
  parameter int unsigned STARVE_MAX = 4
)
`endif
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        pipe_req,
  input  logic [11:0] pipe_addr,
  input  logic [1:0]  pipe_op,
  input  logic [31:0] pipe_wdata,
  output logic        pipe_done,
  output logic [31:0] pipe_rdata,
  output logic        pipe_err,
  input  logic        dbg_req,
  input  logic [11:0] dbg_addr,
  input  logic [1:0]  dbg_op,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_done,
  output logic [31:0] dbg_rdata,
  output logic        dbg_err,
  input  logic        trap_hold,
  output logic [11:0] csr_addr,
  output logic        csr_write,
  output logic        csr_set,
  output logic        csr_clear,
  output logic        csr_read_only,
  output logic [31:0] csr_wdata,
  output logic        csr_valid_write,
  input  logic [31:0] csr_rdata,
  input  logic        csr_invalid,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t      state, state_nxt;
  logic [11:0] lat_addr;
  logic [1:0]  lat_op;
  logic [31:0] lat_wdata;
  logic        owner_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        grant_any;
  logic        grant_dbg;
  logic        dbg_favoured;
  logic        issue;

  assign grant_any = !trap_hold && (pipe_req || dbg_req);
  assign grant_dbg = dbg_req && (!pipe_req || dbg_favoured);

`ifdef PRIV_CSR_ARB_RR_EN
  logic rr_pri;

  // Priority passes to whoever did not win the last grant.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rr_pri <= 1'b0;
    end else if (state == IDLE && grant_any) begin
      rr_pri <= !grant_dbg;
    end
  end

  assign dbg_favoured = rr_pri;
`else
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      starve_cnt <= 4'd0;
    end else if (state == IDLE) begin
      if (!dbg_req) begin
        starve_cnt <= 4'd0;
      end else if (grant_any) begin
        if (grant_dbg) begin
          starve_cnt <= 4'd0;
        end else if (starve_cnt != STARVE_LIM) begin
          starve_cnt <= starve_cnt + 4'd1;
        end
      end
    end
  end

  assign dbg_favoured = (starve_cnt == STARVE_LIM);
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = ISSUE;
      ISSUE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lat_addr  <= 12'd0;
      lat_op    <= 2'd0;
      lat_wdata <= 32'd0;
      owner_q   <= 1'b0;
      rdata_q   <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      if (state == IDLE && grant_any) begin
        owner_q   <= grant_dbg;
        lat_addr  <= grant_dbg ? dbg_addr  : pipe_addr;
        lat_op    <= grant_dbg ? dbg_op    : pipe_op;
        lat_wdata <= grant_dbg ? dbg_wdata : pipe_wdata;
      end
      if (issue) begin
        rdata_q <= csr_rdata;
        err_q   <= csr_invalid;
      end
    end
  end

  assign issue           = (state == ISSUE);
  assign csr_addr        = lat_addr;
  assign csr_wdata       = lat_wdata;
  assign csr_read_only   = issue && (lat_op == 2'b00);
  assign csr_write       = issue && (lat_op == 2'b01);
  assign csr_set         = issue && (lat_op == 2'b10);
  assign csr_clear       = issue && (lat_op == 2'b11);
  // An invalid access still reads but must never commit.
  assign csr_valid_write = issue && (lat_op != 2'b00) && !csr_invalid;

  assign pipe_done  = (state == RESP) && !owner_q;
  assign dbg_done   = (state == RESP) && owner_q;
  assign pipe_rdata = rdata_q;
  assign dbg_rdata  = rdata_q;
  assign pipe_err   = pipe_done && err_q;
  assign dbg_err    = dbg_done && err_q;
  assign busy       = (state != IDLE);
  assign owner      = owner_q;

endmodule

// File: tb/tb_priv_1_12_csr_arb.sv
// tb/tb_priv_1_12_csr_arb.sv - directed self-checking bench for priv_1_12_csr_arb
module tb_priv_1_12_csr_arb;

  logic        CLK, RST;
  logic        pipe_req, dbg_req, trap_hold;
  logic [11:0] pipe_addr, dbg_addr;
  logic [1:0]  pipe_op, dbg_op;
  logic [31:0] pipe_wdata, dbg_wdata;
  logic        pipe_done, dbg_done, pipe_err, dbg_err;
  logic [31:0] pipe_rdata, dbg_rdata;
  logic [11:0] csr_addr;
  logic        csr_write, csr_set, csr_clear, csr_read_only, csr_valid_write;
  logic [31:0] csr_wdata, csr_rdata;
  logic        csr_invalid, busy, owner;

  int checks = 0;
  int failures = 0;

`ifdef PRIV_CSR_ARB_RR_EN
  localparam logic        FIRST2   = 1'b1;
  localparam logic [15:0] PAT3     = 16'h0155;
  localparam logic [15:0] PAT6_PRE = 16'h0005;
  localparam logic [15:0] PAT6_POS = 16'h000A;
`else
  localparam logic        FIRST2   = 1'b0;
  localparam logic [15:0] PAT3     = 16'h0210;
  localparam logic [15:0] PAT6_PRE = 16'h0000;
  localparam logic [15:0] PAT6_POS = 16'h0010;
`endif

  priv_1_12_csr_arb dut (
    .CLK(CLK), .RST(RST),
    .pipe_req(pipe_req), .pipe_addr(pipe_addr), .pipe_op(pipe_op), .pipe_wdata(pipe_wdata),
    .pipe_done(pipe_done), .pipe_rdata(pipe_rdata), .pipe_err(pipe_err),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_op(dbg_op), .dbg_wdata(dbg_wdata),
    .dbg_done(dbg_done), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
    .trap_hold(trap_hold),
    .csr_addr(csr_addr), .csr_write(csr_write), .csr_set(csr_set), .csr_clear(csr_clear),
    .csr_read_only(csr_read_only), .csr_wdata(csr_wdata), .csr_valid_write(csr_valid_write),
    .csr_rdata(csr_rdata), .csr_invalid(csr_invalid),
    .busy(busy), .owner(owner)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  // pat[k] is the expected owner of the k-th back-to-back transaction.
  task automatic run_seq(input int n, input logic [15:0] pat, input bit drop);
    for (int k = 0; k < n; k++) begin
      step();
      chk("seq_owner", owner, pat[k]);
      chk("seq_busy", busy, 1);
      step();
      chk("seq_pipe_done", pipe_done, !pat[k]);
      chk("seq_dbg_done", dbg_done, pat[k]);
      if (drop && k == n - 1) begin
        pipe_req = 0;
        dbg_req  = 0;
      end
      step();
    end
  endtask

  initial begin
    RST = 1; pipe_req = 0; dbg_req = 0; trap_hold = 0;
    pipe_addr = 0; pipe_op = 0; pipe_wdata = 0;
    dbg_addr = 0; dbg_op = 0; dbg_wdata = 0;
    csr_rdata = 0; csr_invalid = 0;

    step();
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_pipe_done", pipe_done, 0);
    chk("rst_dbg_done", dbg_done, 0);
    chk("rst_rdata", pipe_rdata, 0);
    chk("rst_csr_addr", csr_addr, 0);
    chk("rst_csr_wdata", csr_wdata, 0);
    chk("rst_strobes", {csr_write, csr_set, csr_clear, csr_read_only, csr_valid_write}, 0);
    RST = 0;

    // single pipeline write
    pipe_req = 1; pipe_addr = 12'h340; pipe_op = 2'b01; pipe_wdata = 32'hDEADBEEF; csr_rdata = 0;
    #1 chk("t1_idle_busy", busy, 0);
    step();
    chk("t1_issue_busy", busy, 1);
    chk("t1_write", csr_write, 1);
    chk("t1_valid_write", csr_valid_write, 1);
    chk("t1_other_ops", {csr_set, csr_clear, csr_read_only}, 0);
    chk("t1_addr", csr_addr, 32'h340);
    chk("t1_wdata", csr_wdata, 32'hDEADBEEF);
    pipe_req = 0;
    step();
    chk("t1_done", pipe_done, 1);
    chk("t1_rdata", pipe_rdata, 0);
    chk("t1_err", pipe_err, 0);
    chk("t1_dbg_done", dbg_done, 0);
    chk("t1_strobes_resp", csr_valid_write, 0);
    step();
    chk("t1_back_idle", busy, 0);
    chk("t1_done_clear", pipe_done, 0);

    // simultaneous requests
    pipe_req = 1; pipe_addr = 12'h300; pipe_op = 2'b00;
    dbg_req = 1; dbg_addr = 12'h7B1; dbg_op = 2'b01; dbg_wdata = 32'h0000_00FF;
    csr_rdata = 32'h0000_1234;
    step();
    chk("t2_first_owner", owner, FIRST2);
    step();
    chk("t2_first_pdone", pipe_done, !FIRST2);
    chk("t2_first_ddone", dbg_done, FIRST2);
    chk("t2_first_rdata", FIRST2 ? dbg_rdata : pipe_rdata, 32'h1234);
    if (FIRST2) dbg_req = 0; else pipe_req = 0;
    csr_rdata = 32'h0000_CAFE;
    step();
    chk("t2_gap_idle", busy, 0);
    step();
    chk("t2_second_owner", owner, !FIRST2);
    step();
    chk("t2_second_pdone", pipe_done, FIRST2);
    chk("t2_second_ddone", dbg_done, !FIRST2);
    chk("t2_second_rdata", FIRST2 ? pipe_rdata : dbg_rdata, 32'hCAFE);
    pipe_req = 0; dbg_req = 0;
    step();

    // both held: starvation pattern (strict alternation under round-robin)
    pipe_req = 1; pipe_op = 2'b01; dbg_req = 1; dbg_op = 2'b00;
    run_seq(10, PAT3, 1'b1);

    // invalid debug set
    dbg_req = 1; dbg_addr = 12'h7B0; dbg_op = 2'b10; csr_invalid = 1; csr_rdata = 32'h55;
    step();
    chk("t4_set", csr_set, 1);
    chk("t4_no_commit", csr_valid_write, 0);
    chk("t4_owner", owner, 1);
    step();
    chk("t4_dbg_done", dbg_done, 1);
    chk("t4_dbg_err", dbg_err, 1);
    chk("t4_dbg_rdata", dbg_rdata, 32'h55);
    chk("t4_pipe_done", pipe_done, 0);
    dbg_req = 0; csr_invalid = 0;
    step();

    // trap hold blocks grants only in IDLE
    trap_hold = 1; pipe_req = 1; pipe_op = 2'b11;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_held_busy", busy, 0);
    end
    trap_hold = 0;
    step();
    chk("t5_grant", busy, 1);
    chk("t5_clear", csr_clear, 1);
    trap_hold = 1;
    step();
    chk("t5_done_under_hold", pipe_done, 1);
    pipe_req = 0;
    step();
    chk("t5_idle", busy, 0);
    trap_hold = 0;

    // reset mid-ISSUE, starve counter must restart
    pipe_req = 1; pipe_op = 2'b01; pipe_addr = 12'h305; dbg_req = 1;
    run_seq(3, PAT6_PRE, 1'b0);
    step();
    chk("t6_issue_owner", owner, 0);
    chk("t6_issue_commit", csr_valid_write, 1);
    RST = 1;
    #1;
    chk("t6_rst_commit", csr_valid_write, 0);
    chk("t6_rst_write", csr_write, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_addr", csr_addr, 0);
    step();
    chk("t6_rst_no_done", {pipe_done, dbg_done}, 0);
    RST = 0;
    run_seq(5, PAT6_POS, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
